// File: rtl/wb_stage.sv
// wb_stage: LC2K write-back stage.
// Picks one of NUM_SRC result buses per instruction and buffers the result
// in a 2-entry elastic FIFO. The FIFO head drives the register-file write
// port. Committed writes go into a short history used for operand
// forwarding to decode, and are counted in retire_cnt.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid && ready are both high. Valid never depends on ready.
// in_ready is a pure function of the registered fill count, so it updates
// only on clock edges and has no combinational path from out_ready.
//
// Parameter legality (NUM_SRC >= 2, 2**SEL_W >= NUM_SRC, FWD_DEPTH >= 1) is
// the integrator's responsibility. Any select value at or above NUM_SRC is
// handled as an illegal select.
module wb_stage #(
  parameter int DATA_W    = 32,
  parameter int NUM_SRC   = 3,
  parameter int SEL_W     = 2,
  parameter int REG_AW    = 3,
  parameter int FWD_DEPTH = 2,
  parameter int ZERO_REG  = 1,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  // upstream side
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          src_sel,
  input  logic                      in_we,
  input  logic [REG_AW-1:0]         in_waddr,
  // register-file / commit side
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  // forwarding lookups from decode
  input  logic [REG_AW-1:0]         fwd_addr_a,
  input  logic [REG_AW-1:0]         fwd_addr_b,
  output logic                      fwd_hit_a,
  output logic                      fwd_hit_b,
  output logic [DATA_W-1:0]         fwd_data_a,
  output logic [DATA_W-1:0]         fwd_data_b,
  // status
  output logic                      err_sel,
  output logic [CNT_W-1:0]          retire_cnt
);

  // FIFO storage. Slot 0 is always the head, and slot 1 holds the second
  // entry when the count is 2. A pop shifts slot 1 down.
  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_data  [2];
  logic              r_we    [2];
  logic [REG_AW-1:0] r_waddr [2];

  // Commit history. Index 0 is the newest write.
  logic              r_hist_valid [FWD_DEPTH];
  logic [REG_AW-1:0] r_hist_addr  [FWD_DEPTH];
  logic [DATA_W-1:0] r_hist_data  [FWD_DEPTH];

  logic              r_err_sel;
  logic [CNT_W-1:0]  r_retire_cnt;

  // Handshake and entry-forming wires.
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_commit;
  logic              w_sel_ok;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_zero_dst;
  logic              w_entry_we;
  logic [DATA_W-1:0] w_entry_data;

  assign w_full   = (r_count == 2'd2);
  assign w_empty  = (r_count == 2'd0);
  assign w_push   = in_valid && !w_full;
  assign w_pop    = !w_empty && out_ready;
  // Only pops of writing entries update the history and the retire count.
  assign w_commit = w_pop && r_we[0];

  // Source mux. An out-of-range select leaves w_sel_ok low and the data at zero.
  always_comb begin
    w_sel_ok   = 1'b0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (32'(src_sel) == k) begin
        w_sel_ok   = 1'b1;
        w_sel_data = src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // A write to r0 is squashed at entry time when r0 is hardwired to zero.
  assign w_zero_dst   = (ZERO_REG != 0) && (in_waddr == '0);
  assign w_entry_we   = in_we && w_sel_ok && !w_zero_dst;
  assign w_entry_data = w_sel_ok ? w_sel_data : '0;

  // FIFO fill and drain. Push and pop together can only happen at count 1:
  // at count 0 there is nothing to pop, and at count 2 the push is refused.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_data[i]  <= '0;
        r_we[i]    <= 1'b0;
        r_waddr[i] <= '0;
      end
    end else begin
      if (w_push && w_pop) begin
        r_data[0]  <= w_entry_data;
        r_we[0]    <= w_entry_we;
        r_waddr[0] <= in_waddr;
      end else if (w_push) begin
        r_data[r_count[0]]  <= w_entry_data;
        r_we[r_count[0]]    <= w_entry_we;
        r_waddr[r_count[0]] <= in_waddr;
        r_count             <= r_count + 2'd1;
      end else if (w_pop) begin
        r_data[0]  <= r_data[1];
        r_we[0]    <= r_we[1];
        r_waddr[0] <= r_waddr[1];
        r_count    <= r_count - 2'd1;
      end
    end
  end

  // Shift each committed write into the forwarding history, newest at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FWD_DEPTH; i++) begin
        r_hist_valid[i] <= 1'b0;
        r_hist_addr[i]  <= '0;
        r_hist_data[i]  <= '0;
      end
    end else if (w_commit) begin
      for (int i = FWD_DEPTH - 1; i > 0; i--) begin
        r_hist_valid[i] <= r_hist_valid[i-1];
        r_hist_addr[i]  <= r_hist_addr[i-1];
        r_hist_data[i]  <= r_hist_data[i-1];
      end
      r_hist_valid[0] <= 1'b1;
      r_hist_addr[0]  <= r_waddr[0];
      r_hist_data[0]  <= r_data[0];
    end
  end

  // Sticky illegal-select flag, set by an accepted push with a bad select.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_sel <= 1'b0;
    end else if (w_push && !w_sel_ok) begin
      r_err_sel <= 1'b1;
    end
  end

  // Count committed register writes. The counter wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retire_cnt <= '0;
    end else if (w_commit) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  // Port-A lookup. Scan oldest to newest so the newest match wins.
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (r_hist_valid[i] && (r_hist_addr[i] == fwd_addr_a)) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = r_hist_data[i];
      end
    end
    if ((ZERO_REG != 0) && (fwd_addr_a == '0)) begin
      fwd_hit_a  = 1'b0;
      fwd_data_a = '0;
    end
  end

  // Port-B lookup. Same scan as port A.
  always_comb begin
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (r_hist_valid[i] && (r_hist_addr[i] == fwd_addr_b)) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = r_hist_data[i];
      end
    end
    if ((ZERO_REG != 0) && (fwd_addr_b == '0)) begin
      fwd_hit_b  = 1'b0;
      fwd_data_b = '0;
    end
  end

  // Output ports are driven straight from registered state.
  assign in_ready   = !w_full;
  assign out_valid  = !w_empty;
  assign rf_we      = !w_empty && r_we[0];
  assign rf_waddr   = r_waddr[0];
  assign rf_wdata   = r_data[0];
  assign err_sel    = r_err_sel;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised, pipelined write-back stage for the LC2K CPU, replacing the single-cycle registered write-data mux. It selects one of NUM_SRC result buses (memory, ALU, PC+1, further sources) per instruction and buffers the result in a 2-entry elastic FIFO with valid/ready handshakes on both sides. It then drives the register-file write port. It also keeps a short history of committed writes for operand forwarding to decode, and counts retired writes.

## Interface
- DATA_W, 32, width of every source bus and of the write data
- NUM_SRC, 3, number of selectable sources (0 = mem, 1 = alu, 2 = pc+1 by convention); must be ≥ 2
- SEL_W, 2, select width; must satisfy 2^SEL_W ≥ NUM_SRC
- REG_AW, 3, register address width (8 LC2K registers)
- FWD_DEPTH, 2, number of committed writes kept for forwarding; must be ≥ 1
- ZERO_REG, 1, when 1, writes to register 0 are squashed and register 0 never forwards
- CNT_W, 16, retire counter width
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  upstream presents an instruction result
- in_ready  output  1  stage can accept this cycle
- src_data  input  NUM_SRC*DATA_W  source buses, source k at bits [k*DATA_W +: DATA_W]
- src_sel  input  SEL_W  source select
- in_we  input  1  instruction writes a register
- in_waddr  input  REG_AW  destination register
- rf_we  output  1  register-file write enable
- rf_waddr  output  REG_AW  register-file write address
- rf_wdata  output  DATA_W  register-file write data
- out_valid  output  1  head entry present
- out_ready  input  1  register file / commit side accepts head
- fwd_addr_a, fwd_addr_b  input  REG_AW  forwarding lookup addresses
- fwd_hit_a, fwd_hit_b  output  1  address found in history
- fwd_data_a, fwd_data_b  output  DATA_W  forwarded value (0 when no hit)
- err_sel  output  1  sticky: a src_sel ≥ NUM_SRC was accepted
- retire_cnt  output  CNT_W  count of committed entries with rf_we = 1

## Operation
- Push: the handshake in_valid && in_ready. The entry stores {data = src_data[src_sel], we, waddr}.
  - src_sel ≥ NUM_SRC: data = 0, we = 0, err_sel set.
  - ZERO_REG = 1 and in_waddr = 0: we = 0.
- FIFO: 2 entries, count in 0..2.
  - in_ready = (count < 2); it does not depend on out_ready.
  - out_valid = (count > 0).
  - rf_we = out_valid && head.we. rf_waddr and rf_wdata always show the head entry.
- Pop: the handshake out_valid && out_ready is a commit.
  - When the head has we = 1, the head's {waddr, data} is shifted into the history and retire_cnt increments, wrapping at 2^CNT_W.
- Push and pop in the same cycle: count is unchanged and order is preserved.
- Forwarding (combinational over the history only):
  - The newest matching valid history entry wins.
  - fwd_addr = 0 with ZERO_REG = 1 never hits.
  - Entries still in the FIFO are not searched; upstream must stall on them.
- Reset, including mid-operation:
  - count = 0, FIFO contents discarded, all history entries invalid, err_sel = 0, retire_cnt = 0.
  - All outputs at reset: in_ready = 1, out_valid = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, fwd_hit_* = 0, fwd_data_* = 0.
  - Inputs during reset are ignored.

## Timing
- Latency: an entry pushed at edge N is at the head from cycle N+1 when the FIFO was empty. Otherwise it reaches the head one cycle after the previous head pops.
- Throughput is 1 entry/cycle while out_ready is held at 1.
- in_ready updates only on clock edges, so it carries no combinational path from out_ready.
- A history update caused by a pop at edge N is visible on fwd_* from cycle N+1.
- err_sel rises in the cycle after the offending push and stays high until reset.
- Full FIFO (count = 2): in_ready = 0 and a push is ignored even if a pop occurs the same cycle; in_ready returns to 1 the cycle after the pop.
- Empty FIFO with out_ready = 1: no commit occurs and rf_we = 0.

## Test plan
- Reset, then push sel=0/1/2 with src_data {mem=0x11, alu=0x22, pc1=0x33}, waddr=3/4/5, we=1, out_ready=1. Required: rf_wdata = 0x11, 0x22, 0x33 on consecutive cycles starting one cycle after the first push, rf_we = 1, retire_cnt = 3.
- Backpressure: out_ready=0 with 3 consecutive pushes. Required: in_ready drops after the 2nd accepted push and the 3rd is held. Raise out_ready: entries commit in order, then in_ready returns to 1.
- Push waddr=0, we=1, data 0x55 with ZERO_REG=1. Required: rf_we = 0, retire_cnt unchanged, fwd on address 0 gives hit = 0.
- Push src_sel=3 with NUM_SRC=3. Required: err_sel = 1 the next cycle, rf_we = 0 for that entry, err_sel still 1 after 10 more cycles, cleared only by reset.
- Commit r2=0xA then r2=0xB, then fwd_addr_a=2. Required: hit = 1 and data = 0xB. With FWD_DEPTH=2, a third commit to r5 still leaves r2 = 0xB visible; a fourth commit to r6 evicts r2 and hit = 0.
- Assert reset while count = 2 and the history is populated. Required: the next cycle shows out_valid = 0, in_ready = 1, fwd_hit_* = 0, retire_cnt = 0, err_sel = 0.
